regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 register block (`registerBlock32`). Two writeback sources share the register block's single write port:
- requester 0: ALU writeback
- requester 1: load writeback

The block schedules them round-robin with valid/ready handshakes and drives the register block's `en`/`i3`/`d` write inputs from registered outputs. It also tracks reserved-but-unwritten destination registers so issue logic can stall reads on RAW hazards.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rs`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  ALU write request
- `req0_addr`  in  ADDR_W  ALU destination register
- `req0_data`  in  DATA_W  ALU write data
- `req0_ready`  out  1  ALU request accepted this cycle
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`  same as requester 0, for the load unit
- `rsv_valid`  in  1  reserve a destination register at issue
- `rsv_addr`  in  ADDR_W  register to reserve
- `rd_addr0`, `rd_addr1`  in  ADDR_W  read addresses of the instruction being issued
- `rd_stall`  out  1  a read address has a pending write
- `pend`  out  2^ADDR_W  pending-write bit vector
- `wr_en`  out  1  to register block `en`
- `wr_addr`  out  ADDR_W  to register block `i3`
- `wr_data`  out  DATA_W  to register block `d`
- `byp_hit0`, `byp_hit1`  out  1  bypass match for read port 0 / 1
- `byp_data0`, `byp_data1`  out  DATA_W  bypass data for read port 0 / 1

## Operation
- **Handshake:** a request is accepted when `valid` and `ready` are both high. The requester holds `addr`/`data` stable while `valid` is high and `ready` is low.
- **Arbitration:**
  - `req0_ready`/`req1_ready` are combinational from the `valid` inputs and the `last` pointer.
  - At most one `ready` is high per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester that did not win the most recent contested or uncontested grant is granted.
  - `last` updates on every accept.
  - Reset value of `last` is 1, so requester 0 wins the first contention.
  - The write port never backpressures, so some valid requester is always granted.
- **Address 0:** a write to address 0 is accepted (`ready` high), but `wr_en` stays 0 (r0 is constant zero). A reservation of address 0 is ignored.
- **Scoreboard:**
  - `rsv_valid` sets `pend[rsv_addr]` at the next edge.
  - An accepted write clears `pend[addr]` at the next edge.
  - Same-address set and clear in the same cycle: set wins, because the new reservation stays outstanding.
  - Different addresses: both take effect.
  - A write to a non-pending register is legal and leaves its pend bit at 0.
- **Stall:** `rd_stall = pend[rd_addr0] | pend[rd_addr1]`, combinational from registered `pend`. `pend[0]` is always 0.
- **Reset:** while `rs` is low, all of these are 0: `wr_en`, `wr_addr`, `wr_data`, `pend`, `byp_hit*`, `byp_data*`, `rd_stall`. `last` is 1. `ready` outputs follow `valid` per the arbitration rules even during reset but have no effect. Reset mid-operation discards all reservations and any issued-but-unwritten write.

## Timing
- **Accept to write:** `wr_en`/`wr_addr`/`wr_data` are registered and high for exactly the one cycle after accept. The register block captures them at the following edge, two edges after accept.
- **Throughput:** one write per cycle sustained; back-to-back accepts give back-to-back `wr_en`.
- **Pend clear:** the pend bit clears at the same edge that asserts `wr_en`, so `rd_stall` drops one cycle after accept. The read happens once the register block is written or a bypass covers it.
- **Reserve to stall:** a reservation is visible on `rd_stall` the cycle after `rsv_valid`.

## Configuration
- Macro: `REGFILE_ARB_BYPASS_EN`.
- **Defined:**
  - `byp_hitN = wr_en & (wr_addr == rd_addrN) & (rd_addrN != 0)`.
  - `byp_dataN = wr_data` when `byp_hitN`, else 0.
  - `rd_stall` additionally masks any read address covered by a bypass hit.
- **Undefined:** `byp_hit*` and `byp_data*` are tied to 0, and `rd_stall` is exactly the pend lookup. Ports stay present so the interface is identical in both builds.

## Structure
- Package `regfile_arb_pkg`:
  - `DATA_W`, `ADDR_W`, `NREGS` constants
  - requester-id enum `REQ_ALU`/`REQ_LOAD`
  - write-request struct (`addr`, `data`)
- Sub-module `pend_scoreboard`:
  - holds the pend vector with set/clear/priority logic and the two lookup ports
  - the top level holds arbitration, output registers and bypass

## Test plan
1. `rs` low for 3 cycles, then high with no requests → all outputs 0, `pend` = 0; assert `rs` low mid-burst → `pend` and `wr_en` clear immediately.
2. `req0` valid with addr 5, data `FFFFFFFF` → `req0_ready` high that cycle; next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=`FFFFFFFF`.
3. Both valid for 4 cycles, req0 addr 1 and req1 addr 3 → grants in order 0, 1, 0, 1; the non-granted requester holds its data; `wr_addr` sequence 1, 3, 1, 3.
4. Reserve 7, then `rd_addr0`=7 → `rd_stall`=1 next cycle; write 7 accepted together with `rsv` 7 → `pend[7]` stays 1; a later write 7 → `pend[7]` clears.
5. Write and reserve addr 0 → `ready` high, `wr_en` stays 0, `pend[0]` stays 0.
6. With `REGFILE_ARB_BYPASS_EN`, `wr_en`=1 to addr 9 with `rd_addr1`=9 → `byp_hit1`=1, `byp_data1`=`wr_data`, `rd_stall`=0; without the macro, `byp_hit1` stays 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-block write-port arbiter.
package regfile_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request handshakes and register-block write port.
interface regfile_wr_arbiter_if;
    import regfile_arb_pkg::*;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/regfile_wr_arbiter_pend_scoreboard.sv
// Pending-write bit vector: reservation sets, accepted writes clear, set wins on collision.
module pend_scoreboard #(
    parameter int unsigned ADDR_W = regfile_arb_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rs,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    input  logic [ADDR_W-1:0]      look_addr0,
    input  logic [ADDR_W-1:0]      look_addr1,
    output logic                   look_hit0,
    output logic                   look_hit1,
    output logic [2**ADDR_W-1:0]   pend
);
    import regfile_arb_pkg::*;

    logic [2**ADDR_W-1:0] pend_q;
    logic [2**ADDR_W-1:0] pend_d;

    // Set applied after clear so a fresh reservation outlives the write it races.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_addr] = 1'b0;
        if (set_en) pend_d[set_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign pend      = pend_q;
    assign look_hit0 = pend_q[look_addr0];
    assign look_hit1 = pend_q[look_addr1];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter (ALU / load) with RAW pending-write scoreboard.
// Optional write-data bypass enabled by REGFILE_ARB_BYPASS_EN.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W = regfile_arb_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_arb_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rs,
    regfile_wr_arbiter_if.slave  bus,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    input  logic [ADDR_W-1:0]    rd_addr0,
    input  logic [ADDR_W-1:0]    rd_addr1,
    output logic                 rd_stall,
    output logic [2**ADDR_W-1:0] pend,
    output logic                 byp_hit0,
    output logic                 byp_hit1,
    output logic [DATA_W-1:0]    byp_data0,
    output logic [DATA_W-1:0]    byp_data1
);
    import regfile_arb_pkg::*;

    req_id_e           last_q;
    req_id_e           last_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              acc0_c, acc1_c, acc_c;
    wr_req_t           sel_c;
    logic              look0_c, look1_c;

    // Requester that lost the last grant wins a contention.
    assign bus.req0_ready = bus.req0_valid & (~bus.req1_valid | (last_q == REQ_LOAD));
    assign bus.req1_ready = bus.req1_valid & ~bus.req0_ready;
    assign acc0_c         = bus.req0_valid & bus.req0_ready;
    assign acc1_c         = bus.req1_valid & bus.req1_ready;
    assign acc_c          = acc0_c | acc1_c;

    always_comb begin
        sel_c.addr = bus.req0_addr;
        sel_c.data = bus.req0_data;
        last_d     = last_q;
        if (acc1_c) begin
            sel_c.addr = bus.req1_addr;
            sel_c.data = bus.req1_data;
            last_d     = REQ_LOAD;
        end else if (acc0_c) begin
            last_d     = REQ_ALU;
        end
        // r0 is hard-wired zero: accept the write but never drive the port.
        wr_en_d   = acc_c && (sel_c.addr != '0);
        wr_addr_d = wr_en_d ? sel_c.addr : '0;
        wr_data_d = wr_en_d ? sel_c.data : '0;
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            last_q    <= REQ_LOAD;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    pend_scoreboard #(.ADDR_W(ADDR_W)) u_pend_sb (
        .clk        (clk),
        .rs         (rs),
        .set_en     (rsv_valid),
        .set_addr   (rsv_addr),
        .clr_en     (acc_c),
        .clr_addr   (sel_c.addr),
        .look_addr0 (rd_addr0),
        .look_addr1 (rd_addr1),
        .look_hit0  (look0_c),
        .look_hit1  (look1_c),
        .pend       (pend)
    );

`ifdef REGFILE_ARB_BYPASS_EN
    // The write in flight to the register block can feed a same-cycle read.
    always_comb begin
        byp_hit0  = wr_en_q && (wr_addr_q == rd_addr0) && (rd_addr0 != '0);
        byp_hit1  = wr_en_q && (wr_addr_q == rd_addr1) && (rd_addr1 != '0);
        byp_data0 = byp_hit0 ? wr_data_q : '0;
        byp_data1 = byp_hit1 ? wr_data_q : '0;
    end
`else
    assign byp_hit0  = 1'b0;
    assign byp_hit1  = 1'b0;
    assign byp_data0 = '0;
    assign byp_data1 = '0;
`endif

    assign rd_stall = (look0_c & ~byp_hit0) | (look1_c & ~byp_hit1);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: arbitration/pend model plus write-port scoreboard.
module tb_regfile_wr_arbiter;
    import regfile_arb_pkg::*;

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rs;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr, rd_addr0, rd_addr1;
    logic              rd_stall;
    logic [NREGS-1:0]  pend;
    logic              byp_hit0, byp_hit1;
    logic [DATA_W-1:0] byp_data0, byp_data1;

    regfile_wr_arbiter_if bus_if ();

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rs        (rs),
        .bus       (bus_if),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rd_addr0  (rd_addr0),
        .rd_addr1  (rd_addr1),
        .rd_stall  (rd_stall),
        .pend      (pend),
        .byp_hit0  (byp_hit0),
        .byp_hit1  (byp_hit1),
        .byp_data0 (byp_data0),
        .byp_data1 (byp_data1)
    );

    always #5 clk = ~clk;

    exp_t              q[$];
    exp_t              m_wr;
    exp_t              mon_e;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic              m_last;
    logic [NREGS-1:0]  m_pend;
    logic              m_g0, m_g1;
    bit                mon_en = 1'b0;

    // Drive one cycle of stimulus; advance the model to the state after the next edge.
    task automatic apply(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         input logic rv, input logic [ADDR_W-1:0] ra);
        exp_t e;
        bus_if.req0_valid = v0; bus_if.req0_addr = a0; bus_if.req0_data = d0;
        bus_if.req1_valid = v1; bus_if.req1_addr = a1; bus_if.req1_data = d1;
        rsv_valid = rv; rsv_addr = ra;
        m_g0 = v0 && (!v1 || m_last);
        m_g1 = v1 && !m_g0;
        e.en = 1'b0; e.addr = '0; e.data = '0;
        if (m_g0 && a0 != 0) begin e.en = 1'b1; e.addr = a0; e.data = d0; end
        if (m_g1 && a1 != 0) begin e.en = 1'b1; e.addr = a1; e.data = d1; end
        q.push_back(e);
        m_wr = e;
        if (m_g0) m_pend[a0] = 1'b0;
        if (m_g1) m_pend[a1] = 1'b0;
        if (rv)   m_pend[ra] = 1'b1;
        m_pend[0] = 1'b0;
        if (m_g0)      m_last = 1'b0;
        else if (m_g1) m_last = 1'b1;
    endtask

    function automatic logic exp_stall(input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
        logic h0, h1;
        h0 = 1'b0; h1 = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
        h0 = m_wr.en && (m_wr.addr == r0) && (r0 != 0);
        h1 = m_wr.en && (m_wr.addr == r1) && (r1 != 0);
`endif
        return (m_pend[r0] & !h0) | (m_pend[r1] & !h1);
    endfunction

    // Write-port scoreboard: one expected entry per cycle while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_port_underflow: got wr_en=%0b, no expected entry", bus_if.wr_en);
            end else begin
                mon_e = q.pop_front();
                if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data} !== {mon_e.en, mon_e.addr, mon_e.data}) begin
                    n_fail++;
                    $display("FAIL wr_port: got en=%0b addr=%0d data=%h, want en=%0b addr=%0d data=%h",
                             bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, mon_e.en, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        rs = 1'b0;
        bus_if.req0_valid = 1'b0; bus_if.req0_addr = '0; bus_if.req0_data = '0;
        bus_if.req1_valid = 1'b0; bus_if.req1_addr = '0; bus_if.req1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; rd_addr0 = '0; rd_addr1 = '0;
        m_last = 1'b1; m_pend = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data, pend, rd_stall,
             byp_hit0, byp_hit1, byp_data0, byp_data1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr_en=%0b wr_addr=%0d pend=%h stall=%0b, want all 0",
                     bus_if.wr_en, bus_if.wr_addr, pend, rd_stall);
        end
        bus_if.req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready_single: got %b want 10", {bus_if.req1_ready, bus_if.req0_ready});
        end
        bus_if.req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ready_contend: got %b want 01", {bus_if.req1_ready, bus_if.req0_ready});
        end
        bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
        @(negedge clk);
        rs = 1'b1;
        mon_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({bus_if.wr_en, pend, rd_stall, byp_hit0, byp_hit1} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: wr_en=%0b pend=%h stall=%0b, want 0", bus_if.wr_en, pend, rd_stall);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single_write();
        @(negedge clk);
        apply(1, 5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 01", {bus_if.req1_ready, bus_if.req0_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data} !== {1'b1, 5'd5, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL single_write: got en=%0b addr=%0d data=%h want 1/5/ffffffff",
                     bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] d0, d1;
        d0 = 32'hA000_0000;
        d1 = 32'hB000_0000;
        @(negedge clk);
        apply(0, 0, 0, 1, 6, 32'h6666_6666, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply(1, 1, d0, 1, 3, d1, 0, 0);
            #1;
            n_checks++;
            if ({bus_if.req1_ready, bus_if.req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {bus_if.req1_ready, bus_if.req0_ready},
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (i % 2 == 0) d0 = d0 + 1;
            else            d1 = d1 + 1;
        end
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rd_addr0 = 7; rd_addr1 = 0;
        apply(0, 0, 0, 0, 0, 0, 1, 7);
        @(negedge clk);
        n_checks++;
        if ({pend[7], rd_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL rsv_stall: got pend7=%0b stall=%0b want 1/1", pend[7], rd_stall);
        end
        apply(1, 7, 32'h7777_0001, 0, 0, 0, 1, 7);
        @(negedge clk);
        n_checks++;
        if (pend !== m_pend || pend[7] !== 1'b1 || rd_stall !== exp_stall(rd_addr0, rd_addr1)) begin
            n_fail++;
            $display("FAIL set_wins: got pend=%h stall=%0b want pend=%h stall=%0b",
                     pend, rd_stall, m_pend, exp_stall(rd_addr0, rd_addr1));
        end
        apply(0, 0, 0, 1, 7, 32'h7777_0002, 1, 10);
        @(negedge clk);
        n_checks++;
        if ({pend[7], pend[10]} !== 2'b01 || pend !== m_pend) begin
            n_fail++;
            $display("FAIL clr_and_set: got pend=%h want pend=%h", pend, m_pend);
        end
        apply(1, 8, 32'h8888_0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pend[8] !== 1'b0 || pend !== m_pend || rd_stall !== exp_stall(rd_addr0, rd_addr1)) begin
            n_fail++;
            $display("FAIL write_nonpending: got pend=%h stall=%0b want pend=%h", pend, rd_stall, m_pend);
        end
        apply(1, 10, 32'hAAAA_0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pend !== '0) begin
            n_fail++;
            $display("FAIL pend_drained: got pend=%h want 0", pend);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        rd_addr0 = 0; rd_addr1 = 0;
        apply(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
        #1;
        n_checks++;
        if (bus_if.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %0b want 1", bus_if.req0_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({bus_if.wr_en, pend[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_write: got wr_en=%0b pend0=%0b want 0/0", bus_if.wr_en, pend[0]);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_bypass();
        logic              e_hit;
        logic [DATA_W-1:0] e_data;
        logic              e_stall;
`ifdef REGFILE_ARB_BYPASS_EN
        e_hit = 1'b1; e_data = 32'h9999_1234; e_stall = 1'b0;
`else
        e_hit = 1'b0; e_data = '0; e_stall = 1'b1;
`endif
        @(negedge clk);
        rd_addr0 = 0; rd_addr1 = 9;
        apply(0, 0, 0, 0, 0, 0, 1, 9);
        @(negedge clk);
        n_checks++;
        if (rd_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL byp_pre_stall: got %0b want 1", rd_stall);
        end
        apply(1, 9, 32'h9999_1234, 0, 0, 0, 1, 9);
        @(negedge clk);
        n_checks++;
        if ({byp_hit1, byp_data1, rd_stall, byp_hit0, byp_data0} !== {e_hit, e_data, e_stall, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL bypass_hit1: got hit1=%0b data1=%h stall=%0b hit0=%0b want hit1=%0b data1=%h stall=%0b hit0=0",
                     byp_hit1, byp_data1, rd_stall, byp_hit0, e_hit, e_data, e_stall);
        end
        apply(0, 0, 0, 1, 9, 32'h9999_5678, 0, 0);
        @(negedge clk);
        n_checks++;
        if (pend[9] !== 1'b0 || rd_stall !== 1'b0 || byp_hit1 !== e_hit) begin
            n_fail++;
            $display("FAIL bypass_clear: got pend9=%0b stall=%0b hit1=%0b want 0/0/%0b",
                     pend[9], rd_stall, byp_hit1, e_hit);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic              p0, p1, rv;
        logic [ADDR_W-1:0] a0, a1, ra;
        logic [DATA_W-1:0] d0, d1;
        p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (pend !== m_pend || rd_stall !== exp_stall(rd_addr0, rd_addr1)) begin
                n_fail++;
                $display("FAIL b2b_pend[%0d]: got pend=%h stall=%0b want pend=%h stall=%0b",
                         i, pend, rd_stall, m_pend, exp_stall(rd_addr0, rd_addr1));
            end
            if (!p0) begin p0 = 1'($urandom_range(0, 1)); a0 = ADDR_W'($urandom_range(1, 31)); d0 = $urandom; end
            if (!p1) begin p1 = 1'($urandom_range(0, 1)); a1 = ADDR_W'($urandom_range(1, 31)); d1 = $urandom; end
            if (!p0 && !p1) p0 = 1'b1;
            rv = 1'($urandom_range(0, 1));
            ra = ADDR_W'($urandom_range(0, 31));
            rd_addr0 = ADDR_W'($urandom_range(0, 31));
            rd_addr1 = ADDR_W'($urandom_range(0, 31));
            apply(p0, a0, d0, p1, a1, d1, rv, ra);
            #1;
            n_checks++;
            if ({bus_if.req1_ready, bus_if.req0_ready} !== {m_g1, m_g0}) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: got %b want %b", i,
                         {bus_if.req1_ready, bus_if.req0_ready}, {m_g1, m_g0});
            end
            if (m_g0) p0 = 1'b0;
            if (m_g1) p1 = 1'b0;
        end
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rd_addr0 = 4; rd_addr1 = 0;
        apply(1, 2, 32'h2222_2222, 1, 3, 32'h3333_3333, 1, 4);
        @(negedge clk);
        n_checks++;
        if ({bus_if.wr_en, pend[4]} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pre: got wr_en=%0b pend4=%0b want 1/1", bus_if.wr_en, pend[4]);
        end
        mon_en = 1'b0;
        q.delete();
        bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0; rsv_valid = 1'b0;
        #2 rs = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.wr_en, pend, rd_stall} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got wr_en=%0b pend=%h stall=%0b want 0", bus_if.wr_en, pend, rd_stall);
        end
        @(negedge clk);
        rs = 1'b1;
        m_last = 1'b1; m_pend = '0;
        mon_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        apply(1, 11, 32'hBBBB_0011, 1, 12, 32'hCCCC_0012, 0, 0);
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_first_grant: got %b want 01", {bus_if.req1_ready, bus_if.req0_ready});
        end
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_scoreboard();
        test_addr_zero();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        mon_en = 1'b0;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_port_leftover: got %0d entries want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
